// File: rtl/hqc_decod_ctrl_pkg.sv
// Shared types and parameter helpers for the HQC decode controller.
// Holds the FSM state type, security-level width derivation and default watchdog limit.
package hqc_decod_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_HOLD,
    S_ERR
  } state_t;

  localparam int TIMEOUT_CYC_DEF = 50000;

  function automatic int in_aw_f(input int sec);
    return (sec == 128) ? 8 : 9;
  endfunction

  function automatic int param_k_f(input int sec);
    if (sec == 128) return 16;
    if (sec == 192) return 24;
    return 32;
  endfunction

endpackage

// File: rtl/hqc_wdog_cnt.sv
// Saturating watchdog counter with synchronous clear and count enable.
// Ports: clk, rst (async high), clr, en, inc (saturated cnt+1), expire (en and cnt==LIMIT).
module hqc_wdog_cnt #(
  parameter int W     = 16,
  parameter int LIMIT = 49999
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] inc,
  output logic         expire
);

  logic [W-1:0] cnt;

  assign inc    = (&cnt) ? cnt : cnt + W'(1);
  assign expire = en & (cnt == W'(LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= inc;
    end
  end

endmodule

// File: rtl/hqc_decod_ctrl.sv
// Sequencer for the HQC RM/RS decode datapath: input RAM port arbitration,
// decoder start/watchdog supervision and message hand-off to the host.
// Ports: host_* (RAM load, host_ready_o), go_i/err_clr_i/busy_o/err_o (control),
//   ram_* (RAM port), dec_* (decoder side), msg_* (valid/ready message output).
// Optional HQC_DECOD_CTRL_PERF_EN adds perf_cycles_o: RUN cycles of the last
//   successful decode, valid cycle included.
module hqc_decod_ctrl
  import hqc_decod_ctrl_pkg::*;
#(
  parameter int PARAM_SECURITY = 128,
  parameter int IN_AW          = in_aw_f(PARAM_SECURITY),
  parameter int DIN_W          = 128,
  parameter int PARAM_K        = param_k_f(PARAM_SECURITY),
  parameter int DOUT_W         = 8 * PARAM_K,
  parameter int TIMEOUT_W      = 16,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 host_wr_i,
  input  logic [IN_AW-1:0]     host_addr_i,
  input  logic [DIN_W-1:0]     host_din_i,
  output logic                 host_ready_o,
  input  logic                 go_i,
  input  logic                 err_clr_i,
  output logic                 busy_o,
  output logic                 err_o,
  output logic                 ram_we_o,
  output logic                 ram_rd_o,
  output logic [IN_AW-1:0]     ram_addr_o,
  output logic [DIN_W-1:0]     ram_wdata_o,
  input  logic                 dec_rd_i,
  input  logic [IN_AW-1:0]     dec_addr_i,
  output logic                 dec_start_o,
  input  logic                 dec_busy_i,
  input  logic [DOUT_W-1:0]    dec_dout_i,
  input  logic                 dec_dout_valid_i,
  output logic [DOUT_W-1:0]    msg_o,
  output logic                 msg_valid_o,
`ifdef HQC_DECOD_CTRL_PERF_EN
  output logic [TIMEOUT_W-1:0] perf_cycles_o,
`endif
  input  logic                 msg_ready_i
);

  state_t               state;
  logic                 host_own;
  logic                 wd_expire;
  logic [TIMEOUT_W-1:0] wd_inc;

  // Host keeps the RAM while a message waits for pickup.
  assign host_own     = (state == S_IDLE) || (state == S_HOLD);
  assign host_ready_o = (state == S_IDLE);
  assign busy_o       = (state != S_IDLE);

  assign ram_we_o    = host_own & host_wr_i;
  assign ram_rd_o    = ~host_own & dec_rd_i;
  assign ram_addr_o  = host_own ? host_addr_i : dec_addr_i;
  assign ram_wdata_o = host_din_i;

  hqc_wdog_cnt #(
    .W     (TIMEOUT_W),
    .LIMIT (TIMEOUT_CYC - 1)
  ) u_wdog (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (state == S_START),
    .en     (state == S_RUN),
    .inc    (wd_inc),
    .expire (wd_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      dec_start_o <= 1'b0;
      err_o       <= 1'b0;
      msg_o       <= '0;
      msg_valid_o <= 1'b0;
    end else begin
      dec_start_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // A decoder still busy from an earlier run must not be restarted.
          if (go_i && !dec_busy_i) begin
            state       <= S_START;
            dec_start_o <= 1'b1;
          end
        end
        S_START: state <= S_RUN;
        S_RUN: begin
          // A valid landing in the expiry cycle still wins.
          if (dec_dout_valid_i) begin
            msg_o       <= dec_dout_i;
            msg_valid_o <= 1'b1;
            state       <= S_HOLD;
          end else if (wd_expire) begin
            err_o <= 1'b1;
            state <= S_ERR;
          end
        end
        S_HOLD: begin
          if (msg_ready_i) begin
            msg_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        S_ERR: begin
          if (err_clr_i && !dec_busy_i) begin
            err_o <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HQC_DECOD_CTRL_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cycles_o <= '0;
    end else if (state == S_RUN && dec_dout_valid_i) begin
      perf_cycles_o <= wd_inc;
    end
  end
`else
  logic unused_wd;
  assign unused_wd = ^wd_inc;
`endif

endmodule

// File: tb/tb_hqc_decod_ctrl.sv
// Self-checking bench for hqc_decod_ctrl: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_hqc_decod_ctrl;

  localparam int AW = 8;
  localparam int DW = 128;
  localparam int OW = 128;
  localparam int TW = 16;
`ifdef HQC_DECOD_CTRL_PERF_EN
  localparam int TO = 40;
`else
  localparam int TO = 10;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_RUN   = 2;
  localparam int P_HOLD  = 3;
  localparam int P_ERR   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hwr = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic [DW-1:0] hdin = '0;
  logic          go = 1'b0;
  logic          clr = 1'b0;
  logic          drd = 1'b0;
  logic [AW-1:0] daddr = '0;
  logic          dbusy = 1'b0;
  logic [OW-1:0] dout = '0;
  logic          dvalid = 1'b0;
  logic          ready = 1'b0;

  logic          host_ready_o, busy_o, err_o, ram_we_o, ram_rd_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_wdata_o;
  logic          dec_start_o, msg_valid_o;
  logic [OW-1:0] msg_o;
  logic [TW-1:0] perf;

  hqc_decod_ctrl #(
    .PARAM_SECURITY (128),
    .TIMEOUT_W      (TW),
    .TIMEOUT_CYC    (TO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .host_wr_i        (hwr),
    .host_addr_i      (haddr),
    .host_din_i       (hdin),
    .host_ready_o     (host_ready_o),
    .go_i             (go),
    .err_clr_i        (clr),
    .busy_o           (busy_o),
    .err_o            (err_o),
    .ram_we_o         (ram_we_o),
    .ram_rd_o         (ram_rd_o),
    .ram_addr_o       (ram_addr_o),
    .ram_wdata_o      (ram_wdata_o),
    .dec_rd_i         (drd),
    .dec_addr_i       (daddr),
    .dec_start_o      (dec_start_o),
    .dec_busy_i       (dbusy),
    .dec_dout_i       (dout),
    .dec_dout_valid_i (dvalid),
    .msg_o            (msg_o),
    .msg_valid_o      (msg_valid_o),
`ifdef HQC_DECOD_CTRL_PERF_EN
    .perf_cycles_o    (perf),
`endif
    .msg_ready_i      (ready)
  );

`ifndef HQC_DECOD_CTRL_PERF_EN
  assign perf = '0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase of the decode job, RUN cycles elapsed, outputs.
  int            ph = P_IDLE;
  int            runs = 0;
  logic [OW-1:0] m_msg = '0;
  logic          m_vld = 1'b0;
  logic          m_err = 1'b0;
  logic          m_start = 1'b0;
  logic [TW-1:0] m_perf = '0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ph = P_IDLE; runs = 0; m_msg = '0;
      m_vld = 1'b0; m_err = 1'b0; m_start = 1'b0; m_perf = '0;
    end else begin
      m_start = 1'b0;
      if (ph == P_IDLE) begin
        if (go && !dbusy) begin ph = P_START; m_start = 1'b1; end
      end else if (ph == P_START) begin
        runs = 0; ph = P_RUN;
      end else if (ph == P_RUN) begin
        runs = runs + 1;
        if (dvalid) begin
          m_msg = dout; m_vld = 1'b1; m_perf = TW'(runs); ph = P_HOLD;
        end else if (runs == TO) begin
          m_err = 1'b1; ph = P_ERR;
        end
      end else if (ph == P_HOLD) begin
        if (ready) begin m_vld = 1'b0; ph = P_IDLE; end
      end else if (ph == P_ERR) begin
        if (clr && !dbusy) begin m_err = 1'b0; ph = P_IDLE; end
      end
    end
  end

  initial forever begin
    logic host;
    @(negedge clk);
    host = (ph == P_IDLE) || (ph == P_HOLD);
    chk("ram_we", ram_we_o, host ? hwr : 1'b0);
    chk("ram_rd", ram_rd_o, host ? 1'b0 : drd);
    chk("ram_addr", ram_addr_o, host ? haddr : daddr);
    if (host) chk("ram_wdata", ram_wdata_o, hdin);
    chk("host_ready", host_ready_o, ph == P_IDLE);
    chk("busy", busy_o, ph != P_IDLE);
    chk("dec_start", dec_start_o, m_start);
    chk("err", err_o, m_err);
    chk("msg_valid", msg_valid_o, m_vld);
    chk("msg", msg_o, m_msg);
`ifdef HQC_DECOD_CTRL_PERF_EN
    chk("perf", perf, m_perf);
`endif
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic quiet();
    hwr = 0; go = 0; clr = 0; drd = 0; dbusy = 0; dvalid = 0; ready = 0;
  endtask

  localparam logic [127:0] LIT = 128'h0F0E0D0C0B0A09080706050403020100;

  initial begin
    int k;
    logic [OW-1:0] v;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    #1;
    chk("rst_msg", msg_o, 0);
    chk("rst_vld", msg_valid_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_start", dec_start_o, 0);
    chk("rst_ready", host_ready_o, 1);

    // Host load, go together with the last write.
    for (int i = 0; i < 4; i++) begin
      step();
      hwr = 1; haddr = AW'(i); hdin = {4{$urandom}}; go = (i == 3);
      #1;
      chk("load_we", ram_we_o, 1);
      chk("load_addr", ram_addr_o, i);
    end
    step(); go = 0; hwr = 1; haddr = 8'h05; #1;
    chk("start_pulse", dec_start_o, 1);
    chk("start_noready", host_ready_o, 0);
    chk("start_we_drop", ram_we_o, 0);
    step(); #1;
    chk("start_once", dec_start_o, 0);
    chk("run_we_drop", ram_we_o, 0);
    hwr = 0; dvalid = 1; dout = LIT;
    step(); dvalid = 0; dout = {4{$urandom}}; #1;
    chk("msg_valid_lat", msg_valid_o, 1);
    chk("msg_value", msg_o, LIT);
    for (int j = 0; j < 5; j++) begin
      step(); go = 1; #1;
      chk("hold_msg", msg_o, LIT);
      chk("hold_vld", msg_valid_o, 1);
      chk("hold_no_start", dec_start_o, 0);
    end
    step(); go = 0; ready = 1;
    step(); ready = 0; #1;
    chk("back_idle", busy_o, 0);
    chk("vld_cleared", msg_valid_o, 0);

    // Watchdog expiry.
    step(); go = 1;
    k = 0;
    do begin
      step(); go = 0; k++; #1;
    end while (!err_o && k < 200);
    chk("timeout_cycles", k, TO + 2);
    dbusy = 1; clr = 1;
    step(); step(); #1;
    chk("err_hold_busy", err_o, 1);
    dbusy = 0;
    step(); #1;
    chk("err_cleared", err_o, 0);
    chk("idle_after_clr", busy_o, 0);
    quiet();

    // Valid in the expiry cycle.
    step(); go = 1;
    step(); go = 0;
    repeat (TO) step();
    v = {4{$urandom}};
    dvalid = 1; dout = v;
    step(); dvalid = 0; #1;
    chk("edge_valid", msg_valid_o, 1);
    chk("edge_no_err", err_o, 0);
    chk("edge_msg", msg_o, v);
    ready = 1;
    step(); ready = 0;

`ifdef HQC_DECOD_CTRL_PERF_EN
    step(); go = 1;
    step(); go = 0;
    repeat (37) step();
    dvalid = 1; dout = {4{$urandom}};
    step(); dvalid = 0; #1;
    chk("perf_37", perf, 37);
    ready = 1;
    step(); ready = 0;
`endif

    // Asynchronous reset mid-run.
    step(); go = 1;
    step(); go = 0;
    step(); step();
    rst = 1; #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_start", dec_start_o, 0);
    chk("arst_err", err_o, 0);
    chk("arst_vld", msg_valid_o, 0);
    chk("arst_msg", msg_o, 0);
    step(); rst = 0;

    repeat (3000) begin
      step();
      go     = ($urandom % 4) == 0;
      dbusy  = ($urandom % 6) == 0;
      dvalid = ($urandom % 9) == 0;
      ready  = ($urandom % 3) == 0;
      clr    = ($urandom % 3) == 0;
      hwr    = $urandom % 2;
      drd    = $urandom % 2;
      haddr  = AW'($urandom);
      daddr  = AW'($urandom);
      hdin   = {4{$urandom}};
      dout   = {4{$urandom}};
    end
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hqc_decod_ctrl.md
Name: hqc_decod_ctrl

Overview:
Sequencing controller for the HQC decoding datapath (RM decoder followed by RS decoder).
- Owns the decoder's input RAM port and arbitrates it between host codeword loading and decoder reads.
- Issues the one-cycle decoder start pulse and supervises the run with a watchdog.
- Captures the decoded message and presents it to the host over a valid/ready handshake.

Parameters:
PARAM_SECURITY, 128, HQC level (128/192/256); selects the derived widths below.
IN_AW, 8 (9 for 192/256), input RAM address width.
DIN_W, 128, input RAM data width.
PARAM_K, 16 (24/32), message bytes.
DOUT_W, 8*PARAM_K, message width.
TIMEOUT_W, 16, watchdog counter width.
TIMEOUT_CYC, 50000, maximum RUN cycles before error; must be < 2^TIMEOUT_W.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
host_wr_i  in  1  host RAM write strobe.
host_addr_i  in  IN_AW  host write address.
host_din_i  in  DIN_W  host write data.
host_ready_o  out  1  host owns the RAM port; equals (state==IDLE).
go_i  in  1  start-decode pulse.
err_clr_i  in  1  clears the error state.
busy_o  out  1  state != IDLE.
err_o  out  1  watchdog expired.
ram_we_o  out  1  RAM write enable.
ram_rd_o  out  1  RAM read enable.
ram_addr_o  out  IN_AW  RAM address.
ram_wdata_o  out  DIN_W  RAM write data.
dec_rd_i  in  1  decoder RAM read request.
dec_addr_i  in  IN_AW  decoder RAM address.
dec_start_o  out  1  decoder start pulse.
dec_busy_i  in  1  decoder busy.
dec_dout_i  in  DOUT_W  decoded message.
dec_dout_valid_i  in  1  decoded message valid.
msg_o  out  DOUT_W  registered message; byte i = m[i].
msg_valid_o  out  1  message available.
msg_ready_i  in  1  host accepts the message.

Behaviour:
- Reset values:
  - State IDLE.
  - msg_o=0, msg_valid_o=0, err_o=0, dec_start_o=0.
  - Watchdog counter = 0.
  - Reset mid-operation returns to IDLE immediately; any decoder run in progress is abandoned (the decoder has its own reset).
- FSM states: IDLE, START, RUN, HOLD, ERR.
- IDLE:
  - Host owns the port: ram_we_o=host_wr_i, ram_addr_o=host_addr_i, ram_wdata_o=host_din_i, ram_rd_o=0.
  - go_i -> START. A host_wr_i in the same cycle as go_i is still performed.
- START: lasts exactly 1 cycle; dec_start_o=1; counter cleared; -> RUN.
- START/RUN/ERR port ownership:
  - Decoder owns the port: ram_rd_o=dec_rd_i, ram_addr_o=dec_addr_i, ram_we_o=0.
  - host_wr_i is dropped silently; host_ready_o=0.
- RUN:
  - Counter increments each cycle and saturates.
  - dec_dout_valid_i -> msg_o<=dec_dout_i, msg_valid_o<=1, -> HOLD.
  - If the counter reaches TIMEOUT_CYC-1 without valid -> ERR, err_o<=1.
  - If valid arrives in the timeout cycle, valid wins.
  - Latency: go_i to dec_start_o is 1 cycle; dec_dout_valid_i to msg_valid_o is 1 cycle.
- HOLD:
  - msg_o and msg_valid_o are held stable.
  - msg_valid_o & msg_ready_i -> msg_valid_o<=0, -> IDLE.
  - The port returns to the host in HOLD.
- ERR:
  - err_o=1; msg_o is unchanged; late dec_dout_valid_i is ignored.
  - err_clr_i & !dec_busy_i -> err_o<=0, -> IDLE.
  - err_clr_i while dec_busy_i=1 is ignored.
- go_i outside IDLE is ignored (no queueing).
- dec_dout_valid_i outside RUN is ignored.
- dec_start_o never asserts while dec_busy_i=1 from a previous run: entry to START from IDLE is additionally gated by !dec_busy_i. If go_i arrives while dec_busy_i=1, it is dropped.

Optional Feature:
HQC_DECOD_CTRL_PERF_EN:
- Defined:
  - Adds output perf_cycles_o [TIMEOUT_W-1:0].
  - Loaded with the counter value on the RUN->HOLD transition; reset value 0.
  - Holds its last value otherwise, including across ERR.
- Undefined: port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package hqc_decod_ctrl_pkg:
  - State enum.
  - Functions deriving IN_AW and PARAM_K from PARAM_SECURITY.
  - Default TIMEOUT_CYC.
- Sub-module hqc_wdog_cnt: saturating counter with clear, enable and expire-at-limit flag.
- RAM port mux and FSM stay in the top.

Test Plan:
- Write addr 0..3 in IDLE, then go_i -> ram_we_o follows host; dec_start_o high exactly in cycle go+1; host_ready_o=0 from go+1.
- In RUN, drive dec_dout_valid_i with dec_dout_i=128'h0F0E...00 -> msg_valid_o=1 next cycle, msg_o equal to that value. Hold msg_ready_i=0 for 5 cycles -> msg_o stable. Pulse ready -> IDLE.
- TIMEOUT_CYC=10, no valid -> err_o=1 after 10 RUN cycles. err_clr_i with dec_busy_i=1 -> stays in ERR. Drop busy, then clear -> IDLE, err_o=0.
- dec_dout_valid_i in the same cycle as timeout expiry -> HOLD, err_o=0.
- host_wr_i during RUN -> ram_we_o=0. go_i during HOLD -> no dec_start_o. rst_i asserted in RUN -> all outputs 0 asynchronously.
- With HQC_DECOD_CTRL_PERF_EN, valid 37 cycles after START -> perf_cycles_o=37.
